la_pattern_ctrl: RTL and testbench

- Sequencer for the logic-analyzer test-pattern source.
- Accepts a one-shot configuration: pattern mode, seed, sample period and burst length.
- Produces the `test_data` bus plus a qualifying `data_clk` strobe for the LA capture path, then reports completion.
- Replaces free-running, hard-coded pattern generation with a host-controlled start/stop burst engine.

---
 rtl/la_pat_pkg.sv | 22 ++
 rtl/la_pat_next.sv | 24 ++
 rtl/la_pattern_ctrl.sv | 173 +++++++++++++++++
 tb/tb_la_pattern_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/la_pat_pkg.sv
// Shared types and constants for the logic-analyzer pattern sequencer.
package la_pat_pkg;

  localparam int unsigned DATA_W = 8;
  localparam logic [DATA_W-1:0] LFSR_TAPS = 8'hB8;
  localparam logic [DATA_W-1:0] LFSR_LOCKUP = 8'hFF;

  typedef enum logic [1:0] {
    PAT_ROT   = 2'd0,
    PAT_LFSR  = 2'd1,
    PAT_CNT   = 2'd2,
    PAT_CONST = 2'd3
  } pat_mode_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLoad = 2'd1,
    StRun  = 2'd2,
    StDone = 2'd3
  } la_state_e;

endpackage

// File: rtl/la_pat_next.sv
// Combinational next-value function for the test pattern (rotate, XNOR LFSR, counter, constant).
module la_pat_next
  import la_pat_pkg::*;
(
  input  pat_mode_e         mode_i,
  input  logic [DATA_W-1:0] d_i,
  output logic [DATA_W-1:0] next_o
);

  localparam logic [DATA_W-1:0] One = {{(DATA_W-1){1'b0}}, 1'b1};

  always_comb begin
    next_o = d_i;
    unique case (mode_i)
      PAT_ROT:   next_o = {d_i[DATA_W-2:0], d_i[DATA_W-1]};
      // XNOR feedback: all-zero is a legal state, all-ones is the lock-up state.
      PAT_LFSR:  next_o = {d_i[DATA_W-2:0], ~^(d_i & LFSR_TAPS)};
      PAT_CNT:   next_o = d_i + One;
      PAT_CONST: next_o = d_i;
      default:   next_o = d_i;
    endcase
  end

endmodule

// File: rtl/la_pattern_ctrl.sv
// Start/stop burst sequencer driving test_data and the data_clk strobe for LA capture.
// Optional trigger compare output is enabled by defining LA_PAT_TRIG_EN.
module la_pattern_ctrl
  import la_pat_pkg::*;
#(
  parameter int unsigned DIV_W = 16,
  parameter int unsigned LEN_W = 16
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic [1:0]        cfg_mode,
  input  logic [DATA_W-1:0] cfg_seed,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [LEN_W-1:0]  cfg_len,
`ifdef LA_PAT_TRIG_EN
  input  logic [DATA_W-1:0] cfg_trig,
  output logic              trig_out,
`endif
  output logic              busy,
  output logic              done,
  output logic              data_valid,
  output logic              data_clk,
  output logic [DATA_W-1:0] test_data
);

  localparam logic [DIV_W-1:0] DivOne = DIV_W'(1);
  localparam logic [DIV_W-1:0] DivMin = DIV_W'(2);
  localparam logic [LEN_W-1:0] LenOne = LEN_W'(1);

  la_state_e         state_q, state_d;
  pat_mode_e         mode_q, mode_d;
  logic [DATA_W-1:0] seed_q, seed_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [DIV_W-1:0]  phase_q, phase_d;
  logic [LEN_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              data_clk_q, data_clk_d;
  logic              data_valid_q, data_valid_d;
  logic [DATA_W-1:0] next_data;
  logic [DIV_W-1:0]  half_m1;
  logic [DIV_W-1:0]  last_phase;

  la_pat_next u_next (
    .mode_i (mode_q),
    .d_i    (data_q),
    .next_o (next_data)
  );

  assign half_m1    = (div_q >> 1) - DivOne;
  assign last_phase = div_q - DivOne;

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    seed_d       = seed_q;
    div_d        = div_q;
    len_d        = len_q;
    phase_d      = phase_q;
    count_d      = count_q;
    data_d       = data_q;
    data_clk_d   = data_clk_q;
    data_valid_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start && !stop) begin
          mode_d  = pat_mode_e'(cfg_mode);
          seed_d  = cfg_seed;
          div_d   = (cfg_div < DivMin) ? DivMin : cfg_div;
          len_d   = cfg_len;
          state_d = StLoad;
        end
      end
      StLoad: begin
        if (stop) begin
          state_d    = StIdle;
          data_clk_d = 1'b1;
        end else begin
          data_d       = (mode_q == PAT_LFSR && seed_q == LFSR_LOCKUP) ? '0 : seed_q;
          data_valid_d = 1'b1;
          data_clk_d   = 1'b0;
          phase_d      = '0;
          count_d      = LenOne;
          state_d      = StRun;
        end
      end
      StRun: begin
        if (stop) begin
          state_d    = StIdle;
          data_clk_d = 1'b1;
        end else begin
          phase_d = phase_q + DivOne;
          if (phase_q == half_m1) data_clk_d = 1'b1;
          if (phase_q == last_phase) begin
            // cfg_len of zero means free-running; the count then just wraps.
            if (len_q != '0 && count_q == len_q) begin
              state_d    = StDone;
              data_clk_d = 1'b1;
            end else begin
              data_d       = next_data;
              data_valid_d = 1'b1;
              data_clk_d   = 1'b0;
              phase_d      = '0;
              count_d      = count_q + LenOne;
            end
          end
        end
      end
      StDone: begin
        state_d    = StIdle;
        data_clk_d = 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q      <= StIdle;
      mode_q       <= PAT_ROT;
      seed_q       <= '0;
      div_q        <= DivMin;
      len_q        <= '0;
      phase_q      <= '0;
      count_q      <= '0;
      data_q       <= '0;
      data_clk_q   <= 1'b1;
      data_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      seed_q       <= seed_d;
      div_q        <= div_d;
      len_q        <= len_d;
      phase_q      <= phase_d;
      count_q      <= count_d;
      data_q       <= data_d;
      data_clk_q   <= data_clk_d;
      data_valid_q <= data_valid_d;
    end
  end

`ifdef LA_PAT_TRIG_EN
  logic [DATA_W-1:0] trig_q, trig_d;
  logic              trig_out_q, trig_out_d;

  always_comb begin
    trig_d     = (state_q == StIdle && start && !stop) ? cfg_trig : trig_q;
    trig_out_d = data_valid_d && (data_d == trig_q);
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      trig_q     <= '0;
      trig_out_q <= 1'b0;
    end else begin
      trig_q     <= trig_d;
      trig_out_q <= trig_out_d;
    end
  end

  assign trig_out = trig_out_q;
`endif

  assign busy       = (state_q != StIdle);
  assign done       = (state_q == StDone);
  assign data_valid = data_valid_q;
  assign data_clk   = data_clk_q;
  assign test_data  = data_q;

endmodule

// File: tb/tb_la_pattern_ctrl.sv
// Directed self-checking bench for la_pattern_ctrl; define LA_PAT_TRIG_EN to cover the trigger.
module tb_la_pattern_ctrl;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic        start, stop;
  logic [1:0]  cfg_mode;
  logic [7:0]  cfg_seed;
  logic [15:0] cfg_div;
  logic [15:0] cfg_len;
  logic        busy, done, data_valid, data_clk;
  logic [7:0]  test_data;
`ifdef LA_PAT_TRIG_EN
  logic [7:0]  cfg_trig;
  logic        trig_out;
  int          n_trig, trig_idx;
  logic [7:0]  trig_val;
  logic        trig_dv;
`endif

  int          n_total = 0;
  int          n_bad = 0;
  logic [7:0]  cap [$];
  int          n_done;
  int          cyc_used;

  always #5 sys_clk = ~sys_clk;

  la_pattern_ctrl dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .start      (start),
    .stop       (stop),
    .cfg_mode   (cfg_mode),
    .cfg_seed   (cfg_seed),
    .cfg_div    (cfg_div),
    .cfg_len    (cfg_len),
`ifdef LA_PAT_TRIG_EN
    .cfg_trig   (cfg_trig),
    .trig_out   (trig_out),
`endif
    .busy       (busy),
    .done       (done),
    .data_valid (data_valid),
    .data_clk   (data_clk),
    .test_data  (test_data)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic do_start(input logic [1:0] m, input logic [7:0] s, input logic [15:0] d,
                          input logic [15:0] l);
    cfg_mode = m;
    cfg_seed = s;
    cfg_div  = d;
    cfg_len  = l;
    start    = 1'b1;
    stop     = 1'b0;
    tick();
    start    = 1'b0;
  endtask

  // Runs until busy drops, capturing test_data at every data_valid pulse.
  task automatic run_until_idle(input int max_cyc);
    cap.delete();
    n_done   = 0;
    cyc_used = 0;
`ifdef LA_PAT_TRIG_EN
    n_trig = 0;
`endif
    for (int i = 0; i < max_cyc; i++) begin
      tick();
      cyc_used++;
      if (data_valid) cap.push_back(test_data);
      if (done) n_done++;
`ifdef LA_PAT_TRIG_EN
      if (trig_out) begin
        n_trig++;
        trig_idx = cap.size();
        trig_val = test_data;
        trig_dv  = data_valid;
      end
`endif
      if (!busy) break;
    end
    check("burst_timeout", {31'd0, busy}, 32'd0);
  endtask

  logic [1:14] rot_valid = 14'b10001000100000;
  logic [1:14] rot_clk   = 14'b00110011001111;
  logic [1:14] rot_done  = 14'b00000000000010;
  logic [1:14] rot_busy  = 14'b11111111111110;
  logic [7:0]  rot_data [14] = '{8'h88, 8'h88, 8'h88, 8'h88, 8'h11, 8'h11, 8'h11, 8'h11,
                                 8'h22, 8'h22, 8'h22, 8'h22, 8'h22, 8'h22};
  logic [7:0]  lfsr_exp [6] = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h0F, 8'h1E};
  logic [7:0]  last_val;

  initial begin
    sys_rst_n = 1'b0;
    start     = 1'b0;
    stop      = 1'b0;
    cfg_mode  = 2'd0;
    cfg_seed  = 8'h00;
    cfg_div   = 16'd0;
    cfg_len   = 16'd0;
`ifdef LA_PAT_TRIG_EN
    cfg_trig  = 8'h00;
`endif
    tick();
    tick();
    check("rst_data", {24'd0, test_data}, 32'h00);
    check("rst_clk", {31'd0, data_clk}, 32'd1);
    check("rst_valid", {31'd0, data_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    sys_rst_n = 1'b1;
    tick();

    // Rotate burst, cycle-by-cycle.
    do_start(2'd0, 8'h88, 16'd4, 16'd3);
    check("rot_busy0", {31'd0, busy}, 32'd1);
    check("rot_valid0", {31'd0, data_valid}, 32'd0);
    for (int k = 1; k <= 14; k++) begin
      tick();
      check($sformatf("rot_valid%0d", k), {31'd0, data_valid}, {31'd0, rot_valid[k]});
      check($sformatf("rot_clk%0d", k), {31'd0, data_clk}, {31'd0, rot_clk[k]});
      check($sformatf("rot_done%0d", k), {31'd0, done}, {31'd0, rot_done[k]});
      check($sformatf("rot_busy%0d", k), {31'd0, busy}, {31'd0, rot_busy[k]});
      check($sformatf("rot_data%0d", k), {24'd0, test_data}, {24'd0, rot_data[k-1]});
    end

    // LFSR from zero, then from the lock-up seed which must map to zero.
    for (int r = 0; r < 2; r++) begin
      do_start(2'd1, (r == 0) ? 8'h00 : 8'hFF, 16'd2, 16'd6);
      run_until_idle(40);
      check("lfsr_cnt", cap.size(), 32'd6);
      check("lfsr_done", n_done, 32'd1);
      check("lfsr_cycles", cyc_used, 32'd14);
      for (int i = 0; i < 6 && i < cap.size(); i++)
        check($sformatf("lfsr%0d_v%0d", r, i), {24'd0, cap[i]}, {24'd0, lfsr_exp[i]});
    end

    // Continuous counter beyond 256 samples, then stop.
    do_start(2'd2, 8'hFE, 16'd3, 16'd0);
    cap.delete();
    n_done = 0;
    for (int i = 0; i < 800 && cap.size() < 260; i++) begin
      tick();
      if (data_valid) cap.push_back(test_data);
      if (done) n_done++;
    end
    check("cnt_samples", cap.size(), 32'd260);
    if (cap.size() == 260) begin
      check("cnt_v0", {24'd0, cap[0]}, 32'hFE);
      check("cnt_v1", {24'd0, cap[1]}, 32'hFF);
      check("cnt_v2", {24'd0, cap[2]}, 32'h00);
      check("cnt_v257", {24'd0, cap[257]}, 32'hFF);
      check("cnt_v259", {24'd0, cap[259]}, 32'h01);
    end
    check("cnt_no_done", n_done, 32'd0);
    check("cnt_busy", {31'd0, busy}, 32'd1);
    last_val = test_data;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("stop_busy", {31'd0, busy}, 32'd0);
    check("stop_clk", {31'd0, data_clk}, 32'd1);
    check("stop_done", {31'd0, done}, 32'd0);
    check("stop_hold", {24'd0, test_data}, {24'd0, last_val});
    check("stop_hold_val", {24'd0, test_data}, 32'h01);

    // Div 0 clamps to period 2; a start mid-burst with new config is ignored.
    do_start(2'd2, 8'h10, 16'd0, 16'd3);
    cap.delete();
    n_done   = 0;
    cyc_used = 0;
    for (int i = 1; i <= 20; i++) begin
      if (i == 2) begin
        start    = 1'b1;
        cfg_mode = 2'd3;
        cfg_seed = 8'hAA;
        cfg_div  = 16'd9;
      end else begin
        start = 1'b0;
      end
      tick();
      cyc_used = i;
      if (data_valid) cap.push_back(test_data);
      if (done) n_done++;
      if (!busy) break;
    end
    check("clamp_cycles", cyc_used, 32'd8);
    check("clamp_cnt", cap.size(), 32'd3);
    check("clamp_done", n_done, 32'd1);
    if (cap.size() == 3) begin
      check("clamp_v0", {24'd0, cap[0]}, 32'h10);
      check("clamp_v1", {24'd0, cap[1]}, 32'h11);
      check("clamp_v2", {24'd0, cap[2]}, 32'h12);
    end

    // Start together with stop in IDLE is ignored.
    cfg_div = 16'd2;
    cfg_len = 16'd2;
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    check("both_busy", {31'd0, busy}, 32'd0);
    tick();
    check("both_busy2", {31'd0, busy}, 32'd0);
    check("both_valid", {31'd0, data_valid}, 32'd0);

    // Reset mid-run, then a normal burst.
    do_start(2'd0, 8'h88, 16'd4, 16'd0);
    for (int i = 0; i < 5; i++) tick();
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    sys_rst_n = 1'b0;
    tick();
    sys_rst_n = 1'b1;
    check("mrst_data", {24'd0, test_data}, 32'h00);
    check("mrst_clk", {31'd0, data_clk}, 32'd1);
    check("mrst_valid", {31'd0, data_valid}, 32'd0);
    check("mrst_busy", {31'd0, busy}, 32'd0);
    check("mrst_done", {31'd0, done}, 32'd0);
    do_start(2'd0, 8'h88, 16'd4, 16'd3);
    run_until_idle(40);
    check("post_cycles", cyc_used, 32'd14);
    check("post_done", n_done, 32'd1);
    check("post_cnt", cap.size(), 32'd3);
    if (cap.size() == 3) begin
      check("post_v0", {24'd0, cap[0]}, 32'h88);
      check("post_v1", {24'd0, cap[1]}, 32'h11);
      check("post_v2", {24'd0, cap[2]}, 32'h22);
    end

`ifdef LA_PAT_TRIG_EN
    cfg_trig = 8'h08;
    do_start(2'd0, 8'h01, 16'd2, 16'd8);
    cfg_trig = 8'h00;
    run_until_idle(40);
    check("trig_count", n_trig, 32'd1);
    check("trig_index", trig_idx, 32'd4);
    check("trig_val", {24'd0, trig_val}, 32'h08);
    check("trig_dv", {31'd0, trig_dv}, 32'd1);
    check("trig_samples", cap.size(), 32'd8);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
